mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MEM pipeline stage, directly downstream of the execute stage. Holds the EX/MEM pipeline register (PC, instr, Res, Data).
//   Performs MIPS loads/stores (lb/lbu/lh/lhu/lw/sb/sh/sw) over a req/ack data-memory port, with byte-lane alignment and
//   load extension. Stalls the pipeline with MemBusy while an access is outstanding; aborts with BusErr on timeout.
// PARAMETERS
//   TIMEOUT  255  max cycles in REQ without mem_ack before abort (1..2^CNT_W-1)
//   CNT_W    8    width of wait counter
// PORTS
//   Clk        in   1   clock, rising edge
//   Rst        in   1   synchronous reset, ACTIVE-LOW (0 = reset, sampled on Clk)
//   PC_in      in   32  PC from execute stage
//   instr_in   in   32  instruction from execute stage
//   Res_in     in   32  ALU/MD result = effective address for ld/st
//   Data_in    in   32  store data (already forwarded upstream)
//   Bubble     in   1   load a NOP (instr=0) instead of the inputs
//   MemBusy    out  1   1 = stage holding; upstream must stall
//   PC, instr  out  32  registered PC / instr of the op in MEM
//   Res        out  32  registered Res_in (pass-through)
//   RdData     out  32  extended load data, valid in DONE
//   AdE        out  1   misaligned ld/st in MEM this cycle (no access made)
//   BusErr     out  1   1-cycle pulse: access aborted by timeout
//   mem_req    out  1   access request, registered
//   mem_we     out  1   1 = store
//   mem_addr   out  32  {Res[31:2],2'b00}
//   mem_be     out  4   byte enables (stores; 4'b1111 for loads)
//   mem_wdata  out  32  lane-replicated store data
//   mem_ack    in   1   access complete this cycle
//   mem_rdata  in   32  read word, valid with mem_ack
// BEHAVIOUR
//   Reset (Rst=0): PC, instr, Res, RdData, mem_* = 0; AdE, BusErr, MemBusy = 0; state IDLE; counter 0.
//   Pipeline reg: loads every edge when !MemBusy (Bubble -> instr=0, PC/Res/Data=0); holds while MemBusy.
//     MemBusy has priority over Bubble.
//   FSM (IDLE, REQ, DONE):
//     IDLE/DONE -> REQ when reg loads an aligned ld/st; else -> IDLE. A misaligned ld/st -> IDLE, AdE=1 while it sits in MEM.
//     REQ: mem_req=1; mem_addr/be/we/wdata stable; MemBusy=1; counter++.
//       mem_ack=1 -> DONE, RdData <= extend(mem_rdata), mem_req<=0.
//       counter==TIMEOUT and !ack -> IDLE, BusErr pulse, mem_req<=0, RdData=0.
//     DONE: MemBusy=0, RdData valid one cycle; next op latches at end of cycle.
//   Latency: non-mem op 1 cycle; ld/st 2 cycles minimum (ack in first REQ cycle), 1+k for ack in k-th REQ cycle.
//   mem_ack outside REQ is ignored.
//   Store lanes: sw be=1111; sh be=addr[1]?1100:0011, wdata={2{Data[15:0]}}; sb be=0001<<addr[1:0], wdata={4{Data[7:0]}}.
//   Load extract (little-endian): byte=rdata[8*addr[1:0]+:8], half=rdata[16*addr[1]+:16];
//     lb/lh sign-extend, lbu/lhu zero-extend, lw whole word.
//   Alignment: lw/sw need addr[1:0]=0; lh/lhu/sh need addr[0]=0; bytes always aligned.
//   Reset mid-REQ: mem_req drops at that edge, state IDLE; memory side must tolerate abandoned request.
// STRUCTURE
//   Package mem_pkg: opcodes LB=6'h20 LH=6'h21 LW=6'h23 LBU=6'h24 LHU=6'h25 SB=6'h28 SH=6'h29 SW=6'h2B;
//     state encoding IDLE/REQ/DONE; is_load/is_store/size decode function.
//   Sub-module mem_align: combinational be/wdata generation, load extraction, misalign detect.
// TESTING
//   1 Rst=0 mid-REQ -> next cycle mem_req=0, MemBusy=0, all outputs 0, state IDLE.
//   2 sw Res=0x100 Data=0xDEADBEEF, ack on 3rd REQ cycle -> be=1111, addr=0x100, MemBusy high 3 cycles, then DONE.
//   3 sb Res=0x103 Data=0x5A -> be=1000, wdata=0x5A5A5A5A. Load mem_rdata=0x80FF7F01 as follows:
//       lb  @0x102 -> 0xFFFFFFFF
//       lbu @0x103 -> 0x00000080
//       lh  @0x102 -> 0xFFFF80FF
//   4 lw Res=0x101 -> AdE=1, mem_req never asserted, MemBusy=0, next instr latches next edge.
//   5 lw with mem_ack held 0 -> BusErr pulse exactly TIMEOUT cycles after REQ entry, mem_req falls, state IDLE.
//   6 Bubble=1 while MemBusy=1 -> instr held (not NOP) until DONE; Bubble in DONE -> instr=0 next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared decode for the MEM stage: load/store opcodes, FSM states, access-size decode.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

  typedef struct packed {
    logic  ld;
    logic  st;
    logic  sext;
    size_t size;
  } op_dec_t;

  function automatic op_dec_t decode(input logic [5:0] opc);
    op_dec_t d;
    d = '0;
    case (opc)
      OP_LB:  begin d.ld = 1'b1; d.sext = 1'b1; d.size = SZ_B; end
      OP_LH:  begin d.ld = 1'b1; d.sext = 1'b1; d.size = SZ_H; end
      OP_LW:  begin d.ld = 1'b1; d.size = SZ_W; end
      OP_LBU: begin d.ld = 1'b1; d.size = SZ_B; end
      OP_LHU: begin d.ld = 1'b1; d.size = SZ_H; end
      OP_SB:  begin d.st = 1'b1; d.size = SZ_B; end
      OP_SH:  begin d.st = 1'b1; d.size = SZ_H; end
      OP_SW:  begin d.st = 1'b1; d.size = SZ_W; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input op_dec_t d, input logic [1:0] off);
    return (d.ld | d.st) &&
           ((d.size == SZ_W && off != 2'b00) || (d.size == SZ_H && off[0]));
  endfunction

  // True when this opcode/offset pair would launch a memory access.
  function automatic logic access_ok(input logic [5:0] opc, input logic [1:0] off);
    op_dec_t d;
    d = decode(opc);
    return (d.ld | d.st) && !misaligned(d, off);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store enables/replication, little-endian load extract/extend, misalign flag.
module mem_align
  import mem_pkg::*;
(
  input  op_dec_t     dec,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        ade
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = rdata[{off, 3'b000} +: 8];
    h       = rdata[{off[1], 4'b0000} +: 16];
    be      = 4'b0000;
    wdata   = '0;
    ld_data = rdata;
    if (dec.ld) be = 4'b1111;
    if (dec.st) begin
      case (dec.size)
        SZ_H:    begin be = off[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}; end
        SZ_B:    begin be = 4'b0001 << off;             wdata = {4{st_data[7:0]}};  end
        default: begin be = 4'b1111;                    wdata = st_data;            end
      endcase
    end
    case (dec.size)
      SZ_H:    ld_data = {{16{dec.sext & h[15]}}, h};
      SZ_B:    ld_data = {{24{dec.sext & b[7]}}, b};
      default: ld_data = rdata;
    endcase
    ade = misaligned(dec, off);
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register plus a req/ack data-memory FSM with timeout abort.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PC_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] Res_in,
  input  logic [31:0] Data_in,
  input  logic        Bubble,
  output logic        MemBusy,
  output logic [31:0] PC,
  output logic [31:0] instr,
  output logic [31:0] Res,
  output logic [31:0] RdData,
  output logic        AdE,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  state_t           state, nstate;
  op_dec_t          dec_q;
  logic [31:0]      data_q, in_pc, in_instr, in_res, in_data, ld_data;
  logic [CNT_W-1:0] cnt;
  logic             start, abort;

  assign in_pc    = Bubble ? '0 : PC_in;
  assign in_instr = Bubble ? '0 : instr_in;
  assign in_res   = Bubble ? '0 : Res_in;
  assign in_data  = Bubble ? '0 : Data_in;
  assign start    = access_ok(in_instr[31:26], in_res[1:0]);
  assign dec_q    = decode(instr[31:26]);

  assign MemBusy  = (state == REQ);
  assign mem_addr = {Res[31:2], 2'b00};
  assign mem_we   = dec_q.st;

  // Steering works off the registered op so the bus stays stable through REQ.
  mem_align u_align (
    .dec     (dec_q),
    .off     (Res[1:0]),
    .st_data (data_q),
    .rdata   (mem_rdata),
    .be      (mem_be),
    .wdata   (mem_wdata),
    .ld_data (ld_data),
    .ade     (AdE)
  );

  always_comb begin
    nstate = state;
    abort  = 1'b0;
    case (state)
      REQ: begin
        if (mem_ack) nstate = DONE;
        else if (cnt == CNT_W'(TIMEOUT)) begin
          nstate = IDLE;
          abort  = 1'b1;
        end
      end
      default: nstate = start ? REQ : IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= IDLE;
      PC      <= '0;
      instr   <= '0;
      Res     <= '0;
      data_q  <= '0;
      RdData  <= '0;
      BusErr  <= 1'b0;
      mem_req <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= nstate;
      BusErr  <= abort;
      mem_req <= (nstate == REQ);
      if (!MemBusy) begin
        PC     <= in_pc;
        instr  <= in_instr;
        Res    <= in_res;
        data_q <= in_data;
      end
      // cnt holds the 1-based index of the current REQ cycle
      if (state != REQ) cnt <= (nstate == REQ) ? CNT_W'(1) : '0;
      else              cnt <= cnt + CNT_W'(1);
      if (state == REQ && mem_ack) RdData <= ld_data;
      else if (abort)              RdData <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, corner sequences, randomized ops against a reference model.
module tb_mem_stage;
  localparam int TO = 255;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, NOP = 6'h00, ALU = 6'h0F;

  logic        Clk = 1'b0, Rst, Bubble, MemBusy, AdE, BusErr, mem_req, mem_we, mem_ack;
  logic [31:0] PC_in, instr_in, Res_in, Data_in, PC, instr, Res, RdData;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0, errors = 0;

  mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .PC_in(PC_in), .instr_in(instr_in), .Res_in(Res_in),
    .Data_in(Data_in), .Bubble(Bubble), .MemBusy(MemBusy), .PC(PC), .instr(instr),
    .Res(Res), .RdData(RdData), .AdE(AdE), .BusErr(BusErr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] res, data, rdata;
    int          k;
    logic [3:0]  be;
    logic [31:0] wd, rd;
    logic        we, ade;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_pc"}, PC, 0);       chk({nm, "_instr"}, instr, 0);
    chk({nm, "_res"}, Res, 0);     chk({nm, "_rd"}, RdData, 0);
    chk({nm, "_req"}, mem_req, 0); chk({nm, "_we"}, mem_we, 0);
    chk({nm, "_addr"}, mem_addr, 0); chk({nm, "_be"}, mem_be, 0);
    chk({nm, "_wd"}, mem_wdata, 0);  chk({nm, "_ade"}, AdE, 0);
    chk({nm, "_berr"}, BusErr, 0);   chk({nm, "_busy"}, MemBusy, 0);
  endtask

  // Reference model: expected lanes/data from the MIPS rules with plain arithmetic.
  function automatic void model(input logic [5:0] opc, input logic [31:0] res, data, rdata,
                                output logic [3:0] be, output logic [31:0] wd, rd,
                                output logic we, ade);
    int unsigned off, bt, hf;
    logic ld;
    off = res[1:0];
    bt  = (rdata >> (8 * off)) & 32'hFF;
    hf  = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    ld  = (opc == LB || opc == LH || opc == LW || opc == LBU || opc == LHU);
    we  = (opc == SB || opc == SH || opc == SW);
    ade = ((opc == LW || opc == SW) && off != 0) ||
          ((opc == LH || opc == LHU || opc == SH) && (off % 2) != 0);
    be = ld ? 4'hF : 4'h0;
    wd = 0;
    if (opc == SW) begin be = 4'hF; wd = data; end
    if (opc == SH) begin be = (off >= 2) ? 4'hC : 4'h3; wd = (data & 32'hFFFF) * 32'h00010001; end
    if (opc == SB) begin be = 4'(1 << off); wd = (data & 32'hFF) * 32'h01010101; end
    case (opc)
      LB:      rd = (bt >= 128) ? bt - 256 : bt;
      LBU:     rd = bt;
      LH:      rd = (hf >= 32768) ? hf - 65536 : hf;
      LHU:     rd = hf;
      default: rd = rdata;
    endcase
  endfunction

  // Issue one op from EX, answer it with ack in REQ cycle k (0 = never), check every cycle.
  task automatic do_op(input logic [5:0] opc, input logic [31:0] res, data, rdata, input int k,
                       input bit bub, input logic [3:0] e_be, input logic [31:0] e_wd, e_rd,
                       input logic e_we, e_ade);
    logic [31:0] rnd, ins, pc;
    rnd = $urandom; ins = {opc, rnd[25:0]}; pc = $urandom;
    PC_in = pc; instr_in = ins; Res_in = res; Data_in = data; Bubble = bub;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    tick();
    Bubble = 1'b0; mem_ack = 1'b0;
    if (bub) begin
      chk("bubble_instr", instr, 0); chk("bubble_pc", PC, 0); chk("bubble_busy", MemBusy, 0);
      return;
    end
    chk("ld_instr", instr, ins); chk("ld_pc", PC, pc); chk("ld_res", Res, res);
    chk("ade", AdE, e_ade);
    if (e_be == 4'h0 || e_ade) begin
      chk("noacc_req", mem_req, 0); chk("noacc_busy", MemBusy, 0);
      return;
    end
    chk("be", mem_be, e_be); chk("we", mem_we, e_we);
    chk("addr", mem_addr, {res[31:2], 2'b00});
    if (e_we) chk("wdata", mem_wdata, e_wd);
    for (int j = 1; j <= TO; j++) begin
      chk("req_hi", mem_req, 1); chk("req_busy", MemBusy, 1); chk("berr_early", BusErr, 0);
      chk("req_addr", mem_addr, {res[31:2], 2'b00});
      rnd = $urandom; instr_in = rnd; Bubble = rnd[0];
      if (j == k) begin mem_ack = 1'b1; mem_rdata = rdata; end
      else mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0;
      if (j == k) begin
        chk("done_busy", MemBusy, 0); chk("done_req", mem_req, 0); chk("done_berr", BusErr, 0);
        chk("done_instr", instr, ins);
        if (!e_we) chk("rddata", RdData, e_rd);
        return;
      end
    end
    chk("to_berr", BusErr, 1); chk("to_req", mem_req, 0);
    chk("to_busy", MemBusy, 0); chk("to_rd", RdData, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic [5:0] ops [10];
    logic [3:0] be; logic [31:0] wd, rd, res, data, rdata, ins; logic we, ade;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, NOP, ALU};

    tbl.push_back('{SW,  32'h100, 32'hDEADBEEF, 32'h0,        3, 4'hF, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0});
    tbl.push_back('{SB,  32'h103, 32'h0000005A, 32'h0,        1, 4'h8, 32'h5A5A5A5A, 32'h0,        1'b1, 1'b0});
    tbl.push_back('{LB,  32'h102, 32'h0,        32'h80FF7F01, 1, 4'hF, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0});
    tbl.push_back('{LBU, 32'h103, 32'h0,        32'h80FF7F01, 2, 4'hF, 32'h0,        32'h00000080, 1'b0, 1'b0});
    tbl.push_back('{LH,  32'h102, 32'h0,        32'h80FF7F01, 1, 4'hF, 32'h0,        32'hFFFF80FF, 1'b0, 1'b0});
    tbl.push_back('{LW,  32'h101, 32'h0,        32'h0,        1, 4'hF, 32'h0,        32'h0,        1'b0, 1'b1});
    tbl.push_back('{LHU, 32'h100, 32'h0,        32'h80FF7F01, 1, 4'hF, 32'h0,        32'h00007F01, 1'b0, 1'b0});
    tbl.push_back('{LH,  32'h100, 32'h0,        32'h80FF7F01, 2, 4'hF, 32'h0,        32'h00007F01, 1'b0, 1'b0});
    tbl.push_back('{SH,  32'h102, 32'h1234ABCD, 32'h0,        1, 4'hC, 32'hABCDABCD, 32'h0,        1'b1, 1'b0});
    tbl.push_back('{SH,  32'h201, 32'h1234ABCD, 32'h0,        1, 4'h3, 32'h0,        32'h0,        1'b1, 1'b1});
    tbl.push_back('{LB,  32'h101, 32'h0,        32'h80FF7F01, 1, 4'hF, 32'h0,        32'h0000007F, 1'b0, 1'b0});
    tbl.push_back('{NOP, 32'h055, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0});
    tbl.push_back('{SB,  32'h200, 32'h00000011, 32'h0,        2, 4'h1, 32'h11111111, 32'h0,        1'b1, 1'b0});
    tbl.push_back('{LW,  32'h104, 32'h0,        32'h12345678, 4, 4'hF, 32'h0,        32'h12345678, 1'b0, 1'b0});

    Rst = 1'b0; Bubble = 1'b0; mem_ack = 1'b0;
    PC_in = 32'h1234; instr_in = {LW, 26'h0}; Res_in = 32'h40; Data_in = 32'h99; mem_rdata = 0;
    tick(); tick();
    chk_zero("reset");
    Rst = 1'b1;

    foreach (tbl[i])
      do_op(tbl[i].opc, tbl[i].res, tbl[i].data, tbl[i].rdata, tbl[i].k, 1'b0,
            tbl[i].be, tbl[i].wd, tbl[i].rd, tbl[i].we, tbl[i].ade);

    // Reset while a request is outstanding abandons it.
    PC_in = 32'h500; instr_in = {LW, 26'h1}; Res_in = 32'h300; Bubble = 1'b0;
    tick();
    chk("midreq_req", mem_req, 1);
    Rst = 1'b0;
    tick();
    chk_zero("midreq_rst");
    Rst = 1'b1;
    do_op(ALU, 32'h7, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // No ack: abort exactly TO cycles after REQ entry, then a single-cycle pulse.
    do_op(LW, 32'h400, 32'h0, 32'h0, 0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
    Bubble = 1'b1;
    tick();
    chk("berr_pulse", BusErr, 0); chk("berr_bubble", instr, 0);
    Bubble = 1'b0;

    // Bubble during REQ is ignored; Bubble in DONE inserts a NOP.
    ins = {LW, 26'h2ABC};
    PC_in = 32'h600; instr_in = ins; Res_in = 32'h440; Bubble = 1'b0;
    tick();
    Bubble = 1'b1; instr_in = {SW, 26'h0};
    tick();
    chk("hold_instr", instr, ins); chk("hold_busy", MemBusy, 1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    chk("hold_done_instr", instr, ins); chk("hold_done_rd", RdData, 32'hCAFEF00D);
    tick();
    chk("done_bubble_instr", instr, 0); chk("done_bubble_pc", PC, 0);
    Bubble = 1'b0;

    for (int n = 0; n < 200; n++) begin
      logic [5:0] opc;
      opc = ops[$urandom_range(0, 9)];
      res = $urandom; data = $urandom; rdata = $urandom;
      model(opc, res, data, rdata, be, wd, rd, we, ade);
      do_op(opc, res, data, rdata, $urandom_range(1, 4), ($urandom_range(0, 9) == 0),
            be, wd, rd, we, ade);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
